// File: rtl/pipelined_barrel_rotator.sv
// pipelined_barrel_rotator
// Pipelined circular shifter: one registered, binary-weighted rotate stage per
// amount bit, with valid/ready flow control and backpressure on every stage.
// Optional feature macro: PIPELINED_BARREL_ROTATOR_LOGICAL_EN adds up_logical.
// When it is set, a word is zero-filled (logical shift) instead of rotated, and
// right shifts for that word travel as right shifts through the stages.
module pipelined_barrel_rotator #(
    parameter int N = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [AW-1:0] up_amt,
    input  logic          up_dir,
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
    input  logic          up_logical,
`endif
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    // Stage k keeps only the amount bits that stages k+1..AW-1 still need, so
    // the stored amount shrinks by one bit per stage. All of these segments
    // are packed into one triangular vector.
    localparam int TRI = (AW * (AW - 1)) / 2;
    localparam int TW  = (TRI > 0) ? TRI : 1;
    localparam int MW  = (AW > 1) ? (AW - 1) : 1;

    logic [AW-1:0] v_q, v_d;
    logic [N-1:0]  data_q [AW];
    logic [N-1:0]  data_d [AW];
    logic [TW-1:0] amt_q, amt_d;
    logic [AW:0]   rdy;
    logic [AW-1:0] norm_amt;

`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
    // Mode bits travel with the word; the last stage needs none since nothing
    // downstream transforms the word any more.
    logic [MW-1:0] log_q, log_d;
    logic [MW-1:0] rgt_q, rgt_d;
    logic          norm_log;
    logic          norm_rgt;
`endif

    // Input normalisation: circular right rotates become left rotates by the
    // two's complement of the amount (wraps naturally in AW bits).
    always_comb begin
        norm_amt = up_amt;
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
        norm_log = up_logical;
        norm_rgt = up_dir & up_logical;
        if (up_dir && !up_logical) begin
            norm_amt = AW'(0) - up_amt;
        end
`else
        if (up_dir) begin
            norm_amt = AW'(0) - up_amt;
        end
`endif
    end

    assign rdy[AW]    = down_ready;
    assign up_ready   = rdy[0];
    assign down_valid = v_q[AW-1];
    assign down_data  = data_q[AW-1];

    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_stage
            localparam int S   = 1 << gi;
            localparam int OFF = gi * (AW - 1) - (gi * (gi - 1)) / 2;

            logic              in_v;
            logic [N-1:0]      in_data;
            logic [AW-1-gi:0]  in_amt;
            logic [N-1:0]      xf;
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
            logic              in_log;
            logic              in_rgt;
`endif

            if (gi == 0) begin : g_src
                assign in_v    = up_valid;
                assign in_data = up_data;
                assign in_amt  = norm_amt;
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
                assign in_log  = norm_log;
                assign in_rgt  = norm_rgt;
`endif
            end else begin : g_src
                localparam int OFFP = (gi - 1) * (AW - 1) - ((gi - 1) * (gi - 2)) / 2;
                assign in_v    = v_q[gi-1];
                assign in_data = data_q[gi-1];
                assign in_amt  = amt_q[OFFP +: (AW - gi)];
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
                assign in_log  = log_q[gi-1];
                assign in_rgt  = rgt_q[gi-1];
`endif
            end

            // Apply this stage's 2^gi step when the lowest remaining amount bit is set.
            always_comb begin
                xf = in_data;
                if (in_amt[0]) begin
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
                    if (in_log && in_rgt) begin
                        xf = in_data >> S;
                    end else if (in_log) begin
                        xf = in_data << S;
                    end else begin
                        xf = (in_data << S) | (in_data >> (N - S));
                    end
`else
                    xf = (in_data << S) | (in_data >> (N - S));
`endif
                end
            end

            // A stage can take a new word when it is empty or its successor moves.
            assign rdy[gi]    = ~v_q[gi] | rdy[gi+1];
            assign v_d[gi]    = rdy[gi] ? in_v : v_q[gi];
            assign data_d[gi] = rdy[gi] ? xf : data_q[gi];

            if (gi < AW - 1) begin : g_amt
                assign amt_d[OFF +: (AW - 1 - gi)] =
                    rdy[gi] ? in_amt[AW-1-gi:1] : amt_q[OFF +: (AW - 1 - gi)];
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
                assign log_d[gi] = rdy[gi] ? in_log : log_q[gi];
                assign rgt_d[gi] = rdy[gi] ? in_rgt : rgt_q[gi];
`endif
            end
        end

        if (TRI == 0) begin : g_no_amt
            assign amt_d = '0;
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
            assign log_d = '0;
            assign rgt_d = '0;
`endif
        end
    endgenerate

    // Pipeline state register; reset discards every in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            amt_q <= '0;
            for (int i = 0; i < AW; i++) begin
                data_q[i] <= '0;
            end
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
            log_q <= '0;
            rgt_q <= '0;
`endif
        end else begin
            v_q   <= v_d;
            amt_q <= amt_d;
            for (int i = 0; i < AW; i++) begin
                data_q[i] <= data_d[i];
            end
`ifdef PIPELINED_BARREL_ROTATOR_LOGICAL_EN
            log_q <= log_d;
            rgt_q <= rgt_d;
`endif
        end
    end

endmodule

// File: doc/pipelined_barrel_rotator.md
# pipelined_barrel_rotator

Parametrised, pipelined circular shifter: rotates an N-bit word left or right by a per-transaction amount supplied at run time. One binary-weighted rotate stage per amount bit, each registered, with valid/ready flow control and backpressure. Drop-in datapath element for the arithmetic/pipelining blocks (hash mixers, CRC/cipher rounds, alignment) where fixed-amount combinational rotates no longer suffice.

## Interface
- `N`, 8, data width; power of two, N ≥ 2
- `AW`, `$clog2(N)`, amount width and stage count (derived, not overridden)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `up_valid`  in  1  input transaction present
- `up_ready`  out  1  block accepts input this cycle
- `up_data`  in  N  word to rotate
- `up_amt`  in  AW  rotate amount, 0..N-1
- `up_dir`  in  1  0 = rotate left, 1 = rotate right
- `up_logical`  in  1  present only with `PIPELINED_BARREL_ROTATOR_LOGICAL_EN`; 1 = zero-fill shift instead of rotate
- `down_valid`  out  1  result present
- `down_ready`  in  1  consumer accepts result
- `down_data`  out  N  rotated word

## Operation
- Transfer on a port occurs when valid and ready are both high on the same rising edge.
- Input normalisation (combinational, before stage 0): right rotate by s becomes left rotate by (N − s) mod N, computed in AW bits (wrap is natural); amount 0 either direction passes data unchanged.
- Stage k (k = 0..AW−1) holds `v[k]`, data, and remaining amount bits; if amount bit k set, data ← {data[N−1−2^k:0], data[N−1:N−2^k]}, else unchanged. Stage AW−1 output drives `down_*`.
- Per-stage ready: `r[AW] = down_ready`; `r[k] = !v[k] | r[k+1]`; `up_ready = r[0]`. A stage loads when its upstream ready is high; bubbles collapse, throughput one word per cycle when `down_ready` stays high.
- A stage holding valid data with its downstream stalled holds data unchanged; `down_data` stable while `down_valid && !down_ready`.
- `up_amt` ≥ N impossible (AW bits); no error path.
- Left rotate by s: `down_data = (a << s) | (a >> (N − s))` mod 2^N; right: `(a >> s) | (a << (N − s))`.

## Timing
- Reset: all `v[k]` = 0, all stage data = 0; `down_valid` = 0, `down_data` = 0, `up_ready` = 1 in the first cycle after reset release (combinational from cleared valids).
- Latency: AW cycles from input handshake to `down_valid` (N = 8 → 3 cycles) with no stall.
- `up_ready` combinationally depends on `down_ready` (ready chain); no combinational path from `up_data` to `down_data`.
- Simultaneous accept and emit in a full pipeline: legal, occupancy unchanged.
- Reset asserted mid-operation: all in-flight words discarded next edge, no output emitted for them; reset overrides handshake.
- Order preserved; no reordering, no duplication, no loss under arbitrary `down_ready` patterns.

## Configuration
- `PIPELINED_BARREL_ROTATOR_LOGICAL_EN` defined: `up_logical` port exists; a per-stage mode bit travels with the word; when 1, each stage zero-fills vacated bits (left: low bits, right: high bits) and right shifts are carried as right shifts through the stages (no left-rotate normalisation for that word).
- Undefined: port absent, every transaction is a circular rotate; area minimal.

## Test plan
- N = 8, reset then idle: `down_valid` = 0, `down_data` = 0x00, `up_ready` = 1.
- N = 8, data 0xB1, amt 3, dir 0, `down_ready` = 1 → after 3 cycles `down_data` = 0x8D; dir 1 → 0x36; amt 0 either dir → 0xB1.
- N = 8, 8 back-to-back words 0x01, amt 0..7, dir 0 → outputs 0x01,0x02,…,0x80 on consecutive cycles starting cycle 3.
- Backpressure: `down_ready` random 50 %, 200 random transactions → scoreboard matches rotate formula, in order, `down_data` stable while stalled, `up_ready` low only when all 3 stages full and stalled.
- Reset pulse with 3 words in flight → no outputs emitted, next word after reset emerges alone at latency 3.
- With `PIPELINED_BARREL_ROTATOR_LOGICAL_EN`, N = 8: 0xB1, amt 3, logical 1, dir 0 → 0x88; dir 1 → 0x16; N = 32 sweep amt 0..31 both modes against model.
